mpu_clock_gen: RTL and testbench
================================

# mpu_clock_gen

Parametrised 6502 clock generator, successor to the fixed clock divider in the top level. Derives the MPU phase clock from the board clock with a runtime-programmable half-period, and adds free-run, single-step and counted-burst modes. Every started MPU cycle is completed glitch-free, and the clock always parks low. Provides phase-edge strobes and a running cycle count for the bus-monitor and debug logic.

## Interface

Parameters:
- DIV_W, 16, width of the half-period input and the half-period counter.
- BURST_W, 8, width of the burst length.
- CNT_W, 32, width of the MPU cycle counter.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk, input, 1, board clock; all logic sits on its rising edge.
  - rst_n, input, 1, asynchronous active-low reset.
- Mode inputs:
  - run, input, 1, level, already debounced; free-run request.
  - step, input, 1, one-clk pulse; request one MPU cycle.
  - burst_start, input, 1, one-clk pulse; request burst_len MPU cycles.
  - burst_len, input, BURST_W, cycle count for a burst; sampled on the accepting edge.
  - half_period, input, DIV_W, clk cycles per MPU clock phase; 0 is treated as 1.
- Outputs:
  - mpu_clk, output, 1, registered MPU phase clock.
  - phi_rise, output, 1, one-clk strobe coincident with the first high clk of each MPU cycle.
  - phi_fall, output, 1, one-clk strobe coincident with the first low clk of each MPU cycle.
  - busy, output, 1, high while an MPU cycle is in progress.
  - cycle_count, output, CNT_W, number of MPU rising edges since reset; wraps modulo 2^CNT_W.

## Operation

- States: IDLE, RUN, STEP, BURST.
- Effective half-period hp = max(half_period, 1). hp is sampled at the start of each half-phase, so changes apply from the next half-phase.
- **IDLE**
  - mpu_clk=0, busy=0.
  - On a rising edge, the first matching condition wins: run=1 → RUN; burst_start=1 with burst_len≠0 → BURST; step=1 → STEP.
  - burst_start with burst_len=0 is a no-op.
- **Cycle start** (the transition edge out of IDLE):
  - mpu_clk←1, phi_rise←1, half counter←hp-1, cycle_count←cycle_count+1.
  - BURST also loads remaining←burst_len.
- **High phase**: the counter decrements each edge. At counter 0 with mpu_clk=1: mpu_clk←0, phi_fall←1, counter←hp-1.
- **Low phase, end of cycle** (counter 0 with mpu_clk=0):
  - RUN with run=1, or BURST with remaining>1: start the next cycle immediately (same actions as cycle start). BURST decrements remaining.
  - Otherwise: go to IDLE with mpu_clk held 0.
- **Inputs while not IDLE**:
  - run deasserted mid-cycle: the current cycle completes, then IDLE.
  - step and burst_start are ignored (dropped, not queued).
  - run asserted during STEP or BURST is ignored until IDLE is reached; if still high, it is then accepted.
- **Reset**: asynchronous assert at any time. mpu_clk, phi_rise, phi_fall and busy go to 0, cycle_count to 0, state to IDLE, counters to 0. A truncated cycle is acceptable only under reset.

## Timing

- Start latency: request sampled on edge E → mpu_clk=1 from E (registered output, visible in the cycle after E).
- MPU period is exactly 2·hp clk. High and low phases are hp clk each.
- Back-to-back cycles in RUN/BURST have no gap. Separate step requests are separated by at least 1 IDLE clk.
- busy rises with the first mpu_clk high and falls on the edge that enters IDLE. A burst of N cycles gives busy high for N·2·hp clk.
- phi_rise and phi_fall are each exactly one clk wide. They are never both high, and are never high in IDLE.
- cycle_count increments on the same edge as phi_rise. Wrap from all-ones → 0 is silent.

## Test plan

- Reset: hold rst_n=0 with run=1 → mpu_clk=0, busy=0, cycle_count=0. Release → RUN starts on the first edge.
- Single step, half_period=3: one step pulse → mpu_clk high 3 clk then low 3 clk. phi_rise and phi_fall one pulse each; busy high 6 clk; cycle_count=1; back to IDLE low.
- Burst, half_period=2, burst_len=4 → 4 contiguous cycles of period 4 clk, busy high 16 clk, cycle_count +4. A step pulse injected mid-burst → no extra cycle. A burst with burst_len=0 → no activity.
- Run, half_period=5, run dropped 2 clk into a high phase → that cycle completes (5 high + 5 low), then mpu_clk parks low. Set half_period=0 and raise run → period 2 clk.
- half_period changed 10→4 mid high-phase → current half-phase still lasts 10 clk; the following low phase lasts 4.
- Async reset asserted mid high-phase → mpu_clk drops to 0 without waiting for clk. Preload cycle_count near 2^CNT_W-1 via a reduced CNT_W=4 build → wraps 15→0.

Source files
------------

// File: rtl/mpu_clock_gen_if.sv
// Control and status bundle between the MPU clock generator and its users.
interface mpu_clock_gen_if #(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned BURST_W = 8,
  parameter int unsigned CNT_W   = 32
);

  // Mode requests and the programmable half-period.
  logic               run;
  logic               step;
  logic               burst_start;
  logic [BURST_W-1:0] burst_len;
  logic [DIV_W-1:0]   half_period;

  // Generated clock, phase strobes and status.
  logic               mpu_clk;
  logic               phi_rise;
  logic               phi_fall;
  logic               busy;
  logic [CNT_W-1:0]   cycle_count;

  // Controller side: issues requests, observes the clock.
  modport master (
    output run, step, burst_start, burst_len, half_period,
    input  mpu_clk, phi_rise, phi_fall, busy, cycle_count
  );

  // Generator side.
  modport slave (
    input  run, step, burst_start, burst_len, half_period,
    output mpu_clk, phi_rise, phi_fall, busy, cycle_count
  );

endinterface

// File: rtl/mpu_clock_gen.sv
// 6502 phase-clock generator: free-run, single-step and counted-burst modes.
// Every started MPU cycle runs to completion and the clock always parks low.
module mpu_clock_gen #(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned BURST_W = 8,
  parameter int unsigned CNT_W   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  mpu_clock_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    BURST = 2'd3
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   half_cnt;
  logic [BURST_W-1:0] remaining;
  logic               mpu_clk_q;
  logic               phi_rise_q;
  logic               phi_fall_q;
  logic               busy_q;
  logic [CNT_W-1:0]   cycle_cnt_q;

  logic [DIV_W-1:0]   hp_m1_c;
  logic               start_c;
  logic               load_rem_c;
  logic               dec_rem_c;
  logic               to_idle_c;
  state_t             start_mode_c;

  // Reload value for the half-phase counter; a zero half-period behaves as one.
  assign hp_m1_c = (bus.half_period == '0) ? '0 : bus.half_period - DIV_W'(1);

  // Decide whether this edge begins an MPU cycle or ends activity.
  always_comb begin
    start_c      = 1'b0;
    load_rem_c   = 1'b0;
    dec_rem_c    = 1'b0;
    to_idle_c    = 1'b0;
    start_mode_c = state;
    case (state)
      IDLE: begin
        if (bus.run) begin
          start_c      = 1'b1;
          start_mode_c = RUN;
        end else if (bus.burst_start && (bus.burst_len != '0)) begin
          start_c      = 1'b1;
          start_mode_c = BURST;
          load_rem_c   = 1'b1;
        end else if (bus.step) begin
          start_c      = 1'b1;
          start_mode_c = STEP;
        end
      end
      default: begin
        // End of the low phase closes the current MPU cycle.
        if (!mpu_clk_q && (half_cnt == '0)) begin
          if ((state == RUN) && bus.run) begin
            start_c = 1'b1;
          end else if ((state == BURST) && (remaining > BURST_W'(1))) begin
            start_c   = 1'b1;
            dec_rem_c = 1'b1;
          end else begin
            to_idle_c = 1'b1;
          end
        end
      end
    endcase
  end

  // Mode state, half-phase timing and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      half_cnt    <= '0;
      remaining   <= '0;
      mpu_clk_q   <= 1'b0;
      phi_rise_q  <= 1'b0;
      phi_fall_q  <= 1'b0;
      busy_q      <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      phi_rise_q <= 1'b0;
      phi_fall_q <= 1'b0;
      if (start_c) begin
        state       <= start_mode_c;
        mpu_clk_q   <= 1'b1;
        phi_rise_q  <= 1'b1;
        busy_q      <= 1'b1;
        half_cnt    <= hp_m1_c;
        cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
        if (load_rem_c) begin
          remaining <= bus.burst_len;
        end else if (dec_rem_c) begin
          remaining <= remaining - BURST_W'(1);
        end
      end else if (to_idle_c) begin
        state     <= IDLE;
        mpu_clk_q <= 1'b0;
        busy_q    <= 1'b0;
        half_cnt  <= '0;
      end else if (state != IDLE) begin
        if (half_cnt != '0) begin
          half_cnt <= half_cnt - DIV_W'(1);
        end else if (mpu_clk_q) begin
          // End of the high phase: fall and time the low phase.
          mpu_clk_q  <= 1'b0;
          phi_fall_q <= 1'b1;
          half_cnt   <= hp_m1_c;
        end
      end
    end
  end

  assign bus.mpu_clk     = mpu_clk_q;
  assign bus.phi_rise    = phi_rise_q;
  assign bus.phi_fall    = phi_fall_q;
  assign bus.busy        = busy_q;
  assign bus.cycle_count = cycle_cnt_q;

endmodule

// File: tb/tb_mpu_clock_gen.sv
// Directed bench for mpu_clock_gen: vector table plus hand-written corner cases.
module tb_mpu_clock_gen;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mpu_clock_gen_if #(.DIV_W(16), .BURST_W(8), .CNT_W(32)) bus ();
  mpu_clock_gen_if #(.DIV_W(16), .BURST_W(8), .CNT_W(4))  bus4 ();

  mpu_clock_gen #(.DIV_W(16), .BURST_W(8), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mpu_clock_gen #(.DIV_W(16), .BURST_W(8), .CNT_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  typedef struct {
    int unsigned kind;     // 0 = step pulse, 1 = burst pulse
    int unsigned hp;
    int unsigned len;
    bit          inject;   // step pulse injected mid-activity
    int unsigned e_busy;
    int unsigned e_high;
    int unsigned e_rise;
    int unsigned e_fall;
    int unsigned e_runs;   // number of separate busy intervals
  } vec_t;

  vec_t vecs [8];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned exp_cnt  = 0;

  int unsigned obs_high, obs_busy, obs_low, obs_rise, obs_fall, obs_runs;
  int unsigned viol = 0;
  logic        prev_busy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_high  = 0;
    obs_busy  = 0;
    obs_low   = 0;
    obs_rise  = 0;
    obs_fall  = 0;
    obs_runs  = 0;
    prev_busy = 1'b0;
  endtask

  task automatic sample();
    if (bus.mpu_clk) obs_high++;
    if (bus.busy) obs_busy++;
    if (bus.busy && !bus.mpu_clk) obs_low++;
    if (bus.phi_rise) obs_rise++;
    if (bus.phi_fall) obs_fall++;
    if (bus.busy && !prev_busy) obs_runs++;
    prev_busy = bus.busy;
    if ((bus.phi_rise && bus.phi_fall) || ((bus.phi_rise || bus.phi_fall) && !bus.busy))
      viol++;
  endtask

  task automatic observe(input int n);
    for (int k = 0; k < n; k++) begin
      sample();
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;

    //            kind hp len inj busy high rise fall runs
    vecs[0] = '{0, 3, 0, 0,  6, 3, 1, 1, 1};
    vecs[1] = '{0, 1, 0, 0,  2, 1, 1, 1, 1};
    vecs[2] = '{0, 0, 0, 0,  2, 1, 1, 1, 1};
    vecs[3] = '{1, 2, 4, 0, 16, 8, 4, 4, 1};
    vecs[4] = '{1, 2, 4, 1, 16, 8, 4, 4, 1};
    vecs[5] = '{1, 3, 0, 0,  0, 0, 0, 0, 0};
    vecs[6] = '{1, 1, 3, 0,  6, 3, 3, 3, 1};
    vecs[7] = '{1, 4, 1, 0,  8, 4, 1, 1, 1};

    rst_n            = 1'b0;
    bus.run          = 1'b1;
    bus.step         = 1'b0;
    bus.burst_start  = 1'b0;
    bus.burst_len    = '0;
    bus.half_period  = 16'd1;
    bus4.run         = 1'b0;
    bus4.step        = 1'b0;
    bus4.burst_start = 1'b0;
    bus4.burst_len   = '0;
    bus4.half_period = 16'd1;

    // Reset held with run requested.
    repeat (3) tick();
    check("rst_mpu_clk", 64'(bus.mpu_clk), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_count", 64'(bus.cycle_count), 64'd0);
    check("rst_count4", 64'(bus4.cycle_count), 64'd0);

    // Release: free-run starts on the first edge.
    rst_n = 1'b1;
    tick();
    exp_cnt = 1;
    check("rel_mpu_clk", 64'(bus.mpu_clk), 64'd1);
    check("rel_phi_rise", 64'(bus.phi_rise), 64'd1);
    check("rel_count", 64'(bus.cycle_count), 64'(exp_cnt));
    bus.run = 1'b0;
    observe(10);
    check("rel_park", 64'(bus.mpu_clk), 64'd0);
    check("rel_idle", 64'(bus.busy), 64'd0);

    // Table: step and burst requests.
    for (int i = 0; i < 8; i++) begin
      bus.half_period = 16'(vecs[i].hp);
      if (vecs[i].kind == 0) begin
        bus.step = 1'b1;
      end else begin
        bus.burst_start = 1'b1;
        bus.burst_len   = 8'(vecs[i].len);
      end
      tick();
      bus.step        = 1'b0;
      bus.burst_start = 1'b0;
      clear_obs();
      for (int w = 0; w < 40; w++) begin
        if (vecs[i].inject && (w == 5)) bus.step = 1'b1;
        if (w == 6) bus.step = 1'b0;
        sample();
        tick();
      end
      exp_cnt += vecs[i].e_rise;
      check($sformatf("v%0d_busy", i), 64'(obs_busy), 64'(vecs[i].e_busy));
      check($sformatf("v%0d_high", i), 64'(obs_high), 64'(vecs[i].e_high));
      check($sformatf("v%0d_rise", i), 64'(obs_rise), 64'(vecs[i].e_rise));
      check($sformatf("v%0d_fall", i), 64'(obs_fall), 64'(vecs[i].e_fall));
      check($sformatf("v%0d_runs", i), 64'(obs_runs), 64'(vecs[i].e_runs));
      check($sformatf("v%0d_count", i), 64'(bus.cycle_count), 64'(exp_cnt));
      check($sformatf("v%0d_park", i), 64'(bus.mpu_clk), 64'd0);
    end

    // Run dropped two clocks into a high phase: that cycle completes.
    bus.half_period = 16'd5;
    bus.run = 1'b1;
    tick();
    clear_obs();
    observe(2);
    bus.run = 1'b0;
    observe(30);
    exp_cnt += 1;
    check("rundrop_high", 64'(obs_high), 64'd5);
    check("rundrop_low", 64'(obs_low), 64'd5);
    check("rundrop_rise", 64'(obs_rise), 64'd1);
    check("rundrop_park", 64'(bus.mpu_clk), 64'd0);
    check("rundrop_count", 64'(bus.cycle_count), 64'(exp_cnt));

    // Half-period 0 behaves as 1: period of 2 clk.
    bus.half_period = 16'd0;
    bus.run = 1'b1;
    tick();
    clear_obs();
    observe(8);
    check("hp0_rise", 64'(obs_rise), 64'd4);
    check("hp0_fall", 64'(obs_fall), 64'd4);
    check("hp0_high", 64'(obs_high), 64'd4);
    bus.run = 1'b0;
    observe(10);
    exp_cnt += 5;
    check("hp0_park", 64'(bus.mpu_clk), 64'd0);
    check("hp0_count", 64'(bus.cycle_count), 64'(exp_cnt));

    // Half-period change mid high phase applies from the next half-phase.
    bus.half_period = 16'd10;
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    clear_obs();
    observe(3);
    bus.half_period = 16'd4;
    observe(30);
    exp_cnt += 1;
    check("hpchg_high", 64'(obs_high), 64'd10);
    check("hpchg_low", 64'(obs_low), 64'd4);
    check("hpchg_busy", 64'(obs_busy), 64'd14);
    check("hpchg_count", 64'(bus.cycle_count), 64'(exp_cnt));

    // Asynchronous reset mid high phase, away from any clk edge.
    bus.half_period = 16'd6;
    bus.run = 1'b1;
    tick();
    observe(2);
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    check("arst_mpu_clk", 64'(bus.mpu_clk), 64'd0);
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_count", 64'(bus.cycle_count), 64'(exp_cnt));
    bus.run = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_stay_idle", 64'(bus.busy), 64'd0);

    // Narrow counter wraps 15 -> 0 silently.
    bus4.run = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (bus4.phi_rise && (bus4.cycle_count == 4'd15)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("wrap_reach15", 64'(found), 64'd1);
    tick();
    tick();
    check("wrap_rise", 64'(bus4.phi_rise), 64'd1);
    check("wrap_zero", 64'(bus4.cycle_count), 64'd0);
    bus4.run = 1'b0;
    repeat (4) tick();

    check("phi_strobe_rules", 64'(viol), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
